decoder_scan_driver: RTL
========================

DECODER_SCAN_DRIVER -- requirements
Module: decoder_scan_driver

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 16, giving the dwell-count width.
REQ-002 The block SHALL have parameter BLANK_W, default 4, giving the blanking-count width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n as the codebase does.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  begin scanning when idle.
REQ-007 stop  input  1  abort scanning and return to idle.
REQ-008 last_ch  input  3  highest channel index scanned; channels 0..last_ch.
REQ-009 dwell  input  DWELL_W  cycles each channel stays enabled; 0 SHALL be treated as 1.
REQ-010 blank  input  BLANK_W  idle cycles between channels; 0 means no blanking.
REQ-011 sel  output  3  channel index, intended for the a input of the downstream 3-to-8 decoder.
REQ-012 sel_en  output  1  enable, intended for the en input of the downstream decoder.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, ACTIVE and BLANK, and all outputs SHALL be registered.
REQ-016 The block SHALL latch last_ch, dwell (with 0 replaced by 1) and blank on the clock edge that leaves IDLE, and re-latch them at every frame wrap; between latch points, input changes SHALL have no effect.
REQ-017 In IDLE, with start=1 and stop=0, the block SHALL enter ACTIVE on the next edge with sel=0, sel_en=1 and busy=1.
REQ-018 In ACTIVE, sel_en SHALL be 1 for exactly the latched dwell value of consecutive cycles on the current sel.
REQ-019 At the end of an ACTIVE period, sel SHALL advance to sel+1, or to 0 if sel equals the latched last_ch, on the same edge that ends ACTIVE.
REQ-020 After ACTIVE, if the latched blank is greater than 0, the block SHALL enter BLANK for exactly blank cycles with sel_en=0 and sel already at the next value, then return to ACTIVE.
REQ-021 After ACTIVE, if the latched blank equals 0, the block SHALL re-enter ACTIVE directly, so sel_en stays 1 and only sel changes.
REQ-022 frame_done SHALL be 1 for exactly one cycle, the first cycle in which sel=0 after a wrap from last_ch; it SHALL NOT pulse on the initial start.
REQ-023 With last_ch=0, sel SHALL stay 0 and frame_done SHALL pulse once per dwell+blank cycles.
REQ-024 When stop=1 in any state, the next edge SHALL force IDLE with sel=0, sel_en=0, busy=0 and frame_done=0.
REQ-025 When start and stop are both 1, stop SHALL win.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 sel SHALL never exceed the latched last_ch.
REQ-028 sel_en SHALL be 0 whenever the state is IDLE or BLANK.
REQ-029 An illegal state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-030 Asserting rst_n low SHALL immediately force IDLE, sel=0, sel_en=0, busy=0, frame_done=0, all counters 0 and all latched configuration 0.
REQ-031 Asserting reset mid-scan SHALL drop sel_en within the same cycle, with no pulse on frame_done.
REQ-032 After rst_n deasserts, the block SHALL remain in IDLE until start=1 is seen on a rising edge.

Structure
REQ-033 A shared package SHALL hold the state encoding (IDLE=2'd0, ACTIVE=2'd1, BLANK=2'd2) and the default DWELL_W and BLANK_W constants.
REQ-034 A single sub-module, scan_down_counter, SHALL provide a loadable down-counter with a zero flag, instantiated for both dwell and blank timing.
REQ-035 sel/sel_en SHALL connect directly to Decoder3to8 a/en with no glue logic.

Verification
REQ-036 last_ch=7, dwell=3, blank=0, start pulse: sel_en stays 1, sel steps 0..7 every 3 cycles, and frame_done pulses every 24 cycles.
REQ-037 last_ch=2, dwell=2, blank=1: sel_en pattern is 1,1,0 repeating; sel is 0,0,1,1,1,2,2,2,0..., with the sel change coinciding with the 0; frame_done pulses every 9 cycles.
REQ-038 dwell=0, last_ch=1, blank=0: each channel is enabled for 1 cycle, sel alternates 0,1, and frame_done pulses every 2 cycles.
REQ-039 stop asserted mid-ACTIVE on sel=5: next cycle sel=0, sel_en=0, busy=0; a subsequent start restarts at sel=0 with no frame_done.
REQ-040 start and stop high together in IDLE: the block stays IDLE; start while busy: no restart of sel; last_ch changed mid-frame from 7 to 3: the new value takes effect only after the wrap.
REQ-041 rst_n pulsed low asynchronously between edges during BLANK: outputs go to 0 immediately; after release the block stays idle until start.

Source files
------------

// File: rtl/decoder_scan_driver_pkg.sv
// decoder_scan_driver_pkg: state encoding and default widths shared by the scan driver files
package decoder_scan_driver_pkg;
    localparam int DWELL_W_DEF = 16;
    localparam int BLANK_W_DEF = 4;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] BLANK  = 2'd2;
endpackage

// File: rtl/decoder_scan_driver_if.sv
// decoder_scan_driver_if: control inputs and decoder-drive outputs of the scan driver
interface decoder_scan_driver_if
    import decoder_scan_driver_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF,
    parameter int BLANK_W = BLANK_W_DEF
);
    logic               start;
    logic               stop;
    logic [2:0]         last_ch;
    logic [DWELL_W-1:0] dwell;
    logic [BLANK_W-1:0] blank;
    logic [2:0]         sel;
    logic               sel_en;
    logic               busy;
    logic               frame_done;
    modport master(output start, stop, last_ch, dwell, blank, input sel, sel_en, busy, frame_done);
    modport slave(input start, stop, last_ch, dwell, blank, output sel, sel_en, busy, frame_done);
endinterface

// File: rtl/decoder_scan_driver_scan_down_counter.sv
// scan_down_counter: loadable down-counter with a zero flag for dwell and blank timing
module scan_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] val,
    output logic         zero
);
    logic [W-1:0] count;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (load) count <= val;
        else if (dec) count <= count - 1'b1;
    assign zero = count == '0;
endmodule

// File: rtl/decoder_scan_driver.sv
// decoder_scan_driver: scans channels 0..last_ch with per-channel dwell and optional blanking,
// driving the a/en inputs of a downstream 3-to-8 decoder
module decoder_scan_driver
    import decoder_scan_driver_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF,
    parameter int BLANK_W = BLANK_W_DEF
) (
    input logic                  clk,
    input logic                  rst_n,
    decoder_scan_driver_if.slave bus
);
    logic [1:0]         state;
    logic [2:0]         last_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [BLANK_W-1:0] blank_q;
    logic               d_zero, b_zero;
    logic               clr, launch, act_end, wrap, relatch, go_blank, go_active;
    logic [2:0]         last_n;
    logic [DWELL_W-1:0] dwell_n;
    logic [BLANK_W-1:0] blank_n;
    assign clr     = bus.stop || (state != IDLE && state != ACTIVE && state != BLANK);
    assign launch  = state == IDLE && bus.start;
    assign act_end = state == ACTIVE && d_zero;
    assign wrap    = act_end && bus.sel == last_q;
    assign relatch = launch || wrap;
    // Configuration captured on this edge steers the very next period, so use it straight away
    assign last_n    = relatch ? bus.last_ch : last_q;
    assign dwell_n   = relatch ? (bus.dwell == '0 ? DWELL_W'(1) : bus.dwell) : dwell_q;
    assign blank_n   = relatch ? bus.blank : blank_q;
    assign go_blank  = act_end && blank_n != '0;
    assign go_active = launch || (act_end && blank_n == '0) || (state == BLANK && b_zero);
    scan_down_counter #(.W(DWELL_W)) u_dwell (
        .clk(clk), .rst_n(rst_n),
        .load(clr || go_active), .dec(state == ACTIVE && !d_zero),
        .val(clr ? '0 : dwell_n - 1'b1), .zero(d_zero)
    );
    scan_down_counter #(.W(BLANK_W)) u_blank (
        .clk(clk), .rst_n(rst_n),
        .load(clr || go_blank), .dec(state == BLANK && !b_zero),
        .val(clr ? '0 : blank_n - 1'b1), .zero(b_zero)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state          <= IDLE;
            bus.sel        <= '0;
            bus.sel_en     <= 1'b0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
            last_q         <= '0;
            dwell_q        <= '0;
            blank_q        <= '0;
        end else begin
            bus.frame_done <= 1'b0;
            if (clr) begin
                state      <= IDLE;
                bus.sel    <= '0;
                bus.sel_en <= 1'b0;
                bus.busy   <= 1'b0;
            end else begin
                if (relatch) begin
                    last_q  <= last_n;
                    dwell_q <= dwell_n;
                    blank_q <= blank_n;
                end
                if (launch) begin
                    state      <= ACTIVE;
                    bus.sel    <= '0;
                    bus.sel_en <= 1'b1;
                    bus.busy   <= 1'b1;
                end else if (act_end) begin
                    state          <= go_blank ? BLANK : ACTIVE;
                    bus.sel        <= wrap ? 3'd0 : bus.sel + 3'd1;
                    bus.sel_en     <= !go_blank;
                    bus.frame_done <= wrap;
                end else if (state == BLANK && b_zero) begin
                    state      <= ACTIVE;
                    bus.sel_en <= 1'b1;
                end
            end
        end
endmodule
